// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU front end: default width,
// fixed vectors, fetch FSM states and next-PC cause codes.
package cpu_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAIT
  } fetch_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_EXC,
    CAUSE_IRQ,
    CAUSE_EXR,
    CAUSE_IDJ,
    CAUSE_SEQ
  } redirect_cause_e;

  // True for every cause that replaces the sequential flow and therefore
  // discards the word currently being fetched.
  function automatic logic is_redirect(input redirect_cause_e cause);
    return (cause == CAUSE_EXC) || (cause == CAUSE_IRQ) ||
           (cause == CAUSE_EXR) || (cause == CAUSE_IDJ);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: priority between exception, interrupt, EX redirect,
// ID jump and sequential advance, with supervisor-bit protection and
// word alignment of every target.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int               XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0]  ILLOP_VEC = XLEN'(ILLOP_VEC_DEF),
  parameter logic [XLEN-1:0]  XADR_VEC  = XLEN'(XADR_VEC_DEF)
) (
  input  logic [XLEN-1:0] pc,
  input  logic            exc,
  input  logic            irq_ok,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_is_jr,
  input  logic            id_jump,
  input  logic [XLEN-1:0] id_target,
  input  logic            stall,
  input  logic            advance,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] alt_pc,
  output logic [XLEN-1:0] seq_pc,
  output redirect_cause_e cause
);

  // MSB is the supervisor bit; KEEP_MASK keeps the address bits a target
  // may supply (supervisor bit and the two alignment bits come from here).
  localparam logic [XLEN-1:0] MSB_MASK  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] KEEP_MASK = ~(MSB_MASK | XLEN'(3));

  logic sup;
  logic ex_sup;

  // Priority selection; alt_pc is what the flow would do without the
  // interrupt, which is also the return address saved on an interrupt.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    sup     = pc[XLEN-1];
    ex_sup  = ex_is_jr ? (sup & ex_target[XLEN-1]) : sup;
    seq_pc  = ((pc + XLEN'(4)) & ~MSB_MASK) | (pc & MSB_MASK);
    alt_pc  = pc;
    cause   = CAUSE_NONE;

    if (ex_redirect) begin
      alt_pc = (ex_target & KEEP_MASK) | (ex_sup ? MSB_MASK : '0);
      cause  = CAUSE_EXR;
    end else if (id_jump && !stall) begin
      alt_pc = (id_target & KEEP_MASK) | (sup ? MSB_MASK : '0);
      cause  = CAUSE_IDJ;
    end else if (advance && !stall) begin
      alt_pc = seq_pc;
      cause  = CAUSE_SEQ;
    end

    next_pc = alt_pc;
    if (exc) begin
      next_pc = (XADR_VEC & KEEP_MASK) | MSB_MASK;
      cause   = CAUSE_EXC;
    end else if (irq_ok) begin
      next_pc = (ILLOP_VEC & KEEP_MASK) | MSB_MASK;
      cause   = CAUSE_IRQ;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: boot/run/wait FSM, PC register, latched
// interrupt request and the IF/ID pipeline register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0]  ILLOP_VEC = XLEN'(ILLOP_VEC_DEF),
  parameter logic [XLEN-1:0]  XADR_VEC  = XLEN'(XADR_VEC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            exc,
  input  logic            irq,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_is_jr,
  input  logic            id_jump,
  input  logic [XLEN-1:0] id_target,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            irq_taken,
  output logic [XLEN-1:0] irq_epc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc;
  logic            irq_pending;
  logic            fetch_ok;
  logic            irq_ok;
  logic            flush;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] alt_pc;
  logic [XLEN-1:0] seq_pc;
  redirect_cause_e cause;

  // A returned word only counts once the FSM has left BOOT.
  assign fetch_ok  = (state_q != ST_BOOT) && imem_ready;
  // Interrupts are deferred while the supervisor bit is set.
  assign irq_ok    = irq_pending && !pc[XLEN-1];
  assign flush     = is_redirect(cause);
  assign imem_addr = pc;

  pc_next_sel #(
    .XLEN      (XLEN),
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_pc_next_sel (
    .pc          (pc),
    .exc         (exc),
    .irq_ok      (irq_ok),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .ex_is_jr    (ex_is_jr),
    .id_jump     (id_jump),
    .id_target   (id_target),
    .stall       (stall),
    .advance     (fetch_ok),
    .next_pc     (next_pc),
    .alt_pc      (alt_pc),
    .seq_pc      (seq_pc),
    .cause       (cause)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

  // FSM next state and request output.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b1;
    case (state_q)
      ST_BOOT: begin
        imem_req = 1'b0;
        state_d  = ST_RUN;
      end
      ST_RUN:  if (!imem_ready) state_d = ST_WAIT;
      ST_WAIT: if (imem_ready)  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // PC, interrupt latch and interrupt report registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_VEC;
      irq_pending <= 1'b0;
      irq_taken   <= 1'b0;
      irq_epc     <= '0;
    end else begin
      pc        <= next_pc;
      irq_taken <= (cause == CAUSE_IRQ);
      if (cause == CAUSE_IRQ) begin
        // A new irq in the same cycle merges into the one being taken.
        irq_pending <= 1'b0;
        irq_epc     <= alt_pc;
      end else if (irq) begin
        irq_pending <= 1'b1;
      end
    end
  end

  // IF/ID register: flush to bubble, hold on stall, load on a returned word.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else if (flush || (!stall && !fetch_ok)) begin
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else if (!stall) begin
      id_valid    <= 1'b1;
      id_instr    <= imem_rdata;
      id_pc       <= pc;
      id_pc_plus4 <= seq_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a zero-latency instruction memory
// model whose data word is derived from the address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        exc;
  logic        irq;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        ex_is_jr;
  logic        id_jump;
  logic [31:0] id_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        irq_taken;
  logic [31:0] irq_epc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .exc         (exc),
    .irq         (irq),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .ex_is_jr    (ex_is_jr),
    .id_jump     (id_jump),
    .id_target   (id_target),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .irq_taken   (irq_taken),
    .irq_epc     (irq_epc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; exc = 0; irq = 0; ex_redirect = 0; ex_is_jr = 0; id_jump = 0;
    ex_target = '0; id_target = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; imem_ready = 1; clear_ctl();
    tick(); tick();
    check("rst_req",    {31'b0, imem_req},  0);
    check("rst_pc",     imem_addr,          32'h0);
    check("rst_valid",  {31'b0, id_valid},  0);
    check("rst_instr",  id_instr,           0);
    check("rst_idpc",   id_pc,              0);
    check("rst_plus4",  id_pc_plus4,        0);
    check("rst_taken",  {31'b0, irq_taken}, 0);
    check("rst_epc",    irq_epc,            0);

    // Boot then zero-wait streaming
    reset = 0;
    check("boot_req", {31'b0, imem_req}, 0);
    tick();
    check("run_req",    {31'b0, imem_req}, 1);
    check("run_addr0",  imem_addr,         32'h0);
    check("run_valid0", {31'b0, id_valid}, 0);
    tick();
    check("run_addr4",  imem_addr,         32'h4);
    check("run_valid1", {31'b0, id_valid}, 1);
    check("run_idpc0",  id_pc,             32'h0);
    check("run_instr0", id_instr,          32'hC0DE_0000);
    check("run_plus4",  id_pc_plus4,       32'h4);
    tick();
    check("run_addr8",  imem_addr,         32'h8);
    check("run_idpc4",  id_pc,             32'h4);

    // Three wait cycles at PC=0x8
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_addr",  imem_addr,         32'h8);
      check("wait_valid", {31'b0, id_valid}, 0);
      check("wait_instr", id_instr,          0);
    end
    imem_ready = 1;
    tick();
    check("wait_done_addr", imem_addr,   32'hC);
    check("wait_done_idpc", id_pc,       32'h8);
    check("wait_done_inst", id_instr,    32'hC0DE_0008);

    // EX redirect overrides stall and flushes
    stall = 1; ex_redirect = 1; ex_target = 32'h40;
    tick();
    check("exr_stall_pc",    imem_addr,         32'h40);
    check("exr_stall_flush", {31'b0, id_valid}, 0);
    clear_ctl();
    tick();
    check("after_exr_pc",   imem_addr, 32'h44);
    check("after_exr_idpc", id_pc,     32'h40);
    // ID jump ignored under stall, IF/ID held
    stall = 1; id_jump = 1; id_target = 32'h100;
    tick();
    check("idj_stall_pc",    imem_addr,         32'h44);
    check("idj_stall_hold",  {31'b0, id_valid}, 1);
    check("idj_stall_idpc",  id_pc,             32'h40);
    // Accepted ID jump with misaligned target
    stall = 0; id_target = 32'h103;
    tick();
    check("idj_pc",    imem_addr,         32'h100);
    check("idj_flush", {31'b0, id_valid}, 0);
    clear_ctl();

    // Interrupt deferred in kernel, taken after jr to user
    exc = 1;
    tick();
    check("exc_pc", imem_addr, 32'h8000_0008);
    clear_ctl();
    tick();
    check("kern_pc_c", imem_addr, 32'h8000_000C);
    irq = 1;
    tick();
    check("kern_pc_10", imem_addr, 32'h8000_0010);
    stall = 1;  // second irq while pending merges
    tick();
    check("kern_irq_hold", imem_addr,         32'h8000_0010);
    check("kern_no_take",  {31'b0, irq_taken}, 0);
    clear_ctl();
    ex_redirect = 1; ex_is_jr = 1; ex_target = 32'h20;
    tick();
    check("jr_user_pc",  imem_addr,         32'h20);
    check("jr_no_take",  {31'b0, irq_taken}, 0);
    clear_ctl();
    tick();
    check("irq_pc",    imem_addr,          32'h8000_0004);
    check("irq_taken", {31'b0, irq_taken}, 1);
    check("irq_epc",   irq_epc,            32'h24);
    check("irq_flush", {31'b0, id_valid},  0);
    tick();
    check("irq_pulse_end", {31'b0, irq_taken}, 0);
    check("irq_epc_held",  irq_epc,            32'h24);
    check("irq_seq_pc",    imem_addr,          32'h8000_0008);

    // irq together with exc at PC=0x10
    ex_redirect = 1; ex_is_jr = 1; ex_target = 32'h10;
    tick();
    check("jr_to_10", imem_addr, 32'h10);
    clear_ctl();
    irq = 1; exc = 1;
    tick();
    check("exc_wins_pc",  imem_addr,          32'h8000_0008);
    check("exc_wins_tk",  {31'b0, irq_taken}, 0);
    clear_ctl();
    tick();
    check("pend_kern_tk", {31'b0, irq_taken}, 0);
    ex_redirect = 1; ex_is_jr = 1; ex_target = 32'h30;
    tick();
    check("jr_to_30", imem_addr, 32'h30);
    clear_ctl();
    tick();
    check("pend_taken",     {31'b0, irq_taken}, 1);
    check("pend_taken_epc", irq_epc,            32'h34);

    // Supervisor-bit protection
    ex_redirect = 1; ex_is_jr = 1; ex_target = 32'h10;
    tick();
    ex_is_jr = 0; ex_target = 32'h8000_0000;
    tick();
    check("exr_no_sup", imem_addr, 32'h0);
    ex_is_jr = 1; ex_target = 32'h8000_0050;
    tick();
    check("jr_no_enter", imem_addr, 32'h50);
    clear_ctl();

    // PC+4 wrap keeps the supervisor bit
    exc = 1;
    tick();
    clear_ctl();
    id_jump = 1; id_target = 32'hFFFF_FFFC;
    tick();
    check("idj_kern_pc", imem_addr, 32'hFFFF_FFFC);
    clear_ctl();
    tick();
    check("wrap_pc",    imem_addr,   32'h8000_0000);
    check("wrap_idpc",  id_pc,       32'hFFFF_FFFC);
    check("wrap_plus4", id_pc_plus4, 32'h8000_0000);

    // Reset in the middle of a wait
    imem_ready = 0;
    tick();
    reset = 1; imem_ready = 1;
    tick();
    check("rst_wait_pc",    imem_addr,         32'h0);
    check("rst_wait_req",   {31'b0, imem_req}, 0);
    check("rst_wait_valid", {31'b0, id_valid}, 0);
    reset = 0;
    tick();
    check("reboot_addr",  imem_addr,         32'h0);
    check("reboot_valid", {31'b0, id_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch stage for the pipelined CPU. It owns the PC register, the instruction-memory request, the IF/ID pipeline register and next-PC selection. Next-PC sources, in priority order: exception, interrupt, EX-stage redirect, ID-stage jump, sequential. Unlike the single-cycle datapath, it tolerates a multi-cycle instruction memory, stalls and flushes, latches interrupts, and protects the supervisor bit.

## Interface
- XLEN, 32: data/address width, ≥16.
- RESET_VEC, 0x00000000: PC after reset.
- ILLOP_VEC, 0x80000004: interrupt vector.
- XADR_VEC, 0x80000008: exception vector.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  equals PC.
- imem_ready  in  1  imem_rdata valid for the current imem_addr this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  hazard unit: hold PC and IF/ID.
- exc  in  1  exception: redirect to XADR_VEC.
- irq  in  1  interrupt request pulse; latched.
- ex_redirect  in  1  branch taken / jr in EX.
- ex_target  in  XLEN  EX redirect target.
- ex_is_jr  in  1  EX redirect is register jump.
- id_jump  in  1  J/JAL decoded in ID.
- id_target  in  XLEN  ID jump target.
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  32  IF/ID instruction; 0 (nop) when invalid.
- id_pc  out  XLEN  PC of id_instr.
- id_pc_plus4  out  XLEN  link value.
- irq_taken  out  1  one-cycle pulse when the interrupt redirect occurs.
- irq_epc  out  XLEN  PC that would have been fetched; valid with irq_taken, held after.

## Operation
- FSM states: BOOT, RUN, WAIT.
  - reset → BOOT. BOOT lasts one cycle with imem_req=0, then → RUN.
  - RUN/WAIT: imem_req=1. RUN→WAIT when imem_ready=0. WAIT→RUN when imem_ready=1.
- irq_pending: set by irq, cleared when taken. The interrupt is taken only when irq_pending=1 and PC[XLEN-1]=0 (user mode). In kernel mode it stays pending.
- Redirect priority: exc > interrupt > ex_redirect > id_jump > PC+4.
  - exc, interrupt and ex_redirect override stall and flush IF/ID.
  - id_jump is ignored while stall=1. When accepted, it flushes the instruction in IF (no delay slot).
- Sequential advance happens only when imem_ready=1 and stall=0. Otherwise PC holds.
- Supervisor bit (PC[XLEN-1]):
  - Vectors set it.
  - ex_redirect without ex_is_jr, and id_jump: the bit is copied from the current PC.
  - ex_is_jr: next bit = PC[XLEN-1] & ex_target[XLEN-1]. jr can leave kernel mode but cannot enter it.
- Target bits [1:0] are forced to 0. Misalignment is not reported.
- PC+4 wraps modulo 2^(XLEN-1) with the supervisor bit preserved.

## Timing
- Reset values: PC=RESET_VEC, imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, irq_taken=0, irq_epc=0, irq_pending=0.
  - The first fetch of RESET_VEC is issued in the cycle after BOOT.
  - reset mid-WAIT discards the outstanding fetch.
- Each clock edge, IF/ID loads as follows:
  - flush: bubble.
  - else stall: hold.
  - else imem_ready: {1, imem_rdata, PC, PC+4}.
  - else: bubble.
- Latency: an instruction word returned with imem_ready in cycle N appears on id_* in cycle N+1. With zero-wait memory, throughput is one instruction per cycle.
- A redirect asserted in cycle N sets PC=target at edge N+1 and discards any imem_rdata in cycle N.
- irq and a redirect in the same cycle: exc wins, and irq_pending stays set. The interrupt beats ex_redirect/id_jump. irq_epc = the target the lower-priority source would have produced.
- irq arriving while irq_pending=1 is merged; only one irq_taken pulse results.

## Structure
- Package cpu_pkg holds XLEN default, the three vectors, the FSM state enum and the redirect-cause enum {NONE, EXC, IRQ, EXR, IDJ, SEQ}.
- One combinational sub-module, pc_next_sel, performs priority selection, supervisor-bit masking and alignment. It also outputs the cause.
- fetch_stage holds the FSM, PC, irq_pending and IF/ID registers.

## Test plan
- Reset with imem_ready=1 held: imem_req=0 for 1 cycle, then addresses 0x0, 0x4, 0x8. id_pc lags imem_addr by one cycle, and id_valid rises in cycle 3.
- imem_ready low for 3 cycles at PC=0x8: PC holds 0x8, three bubbles (id_valid=0, id_instr=0), then id_pc=0x8.
- stall=1 with ex_redirect=1 to 0x40 in the same cycle: next PC=0x40 and IF/ID flushed. A further stall=1 with id_jump=1 to 0x100: ignored, PC held.
- Interrupt while PC=0x80000010: no redirect while kernel. ex_is_jr to 0x00000020: PC=0x00000020. The next cycle redirects to ILLOP_VEC, irq_taken=1, irq_epc=0x00000024.
- irq with exc in the same cycle at PC=0x10: PC=XADR_VEC, irq_pending stays set, and the interrupt is still not taken next cycle because PC is now kernel.
- ex_redirect (non-jr) from PC=0x00000010 to 0x80000000: PC=0x00000000. The supervisor bit is not set.
